wb_text_console: RTL and testbench

WB_TEXT_CONSOLE -- requirements
Module: wb_text_console

---
 rtl/wb_text_console.sv | 202 ++++++++++++++++++++
 tb/tb_wb_text_console.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_text_console.sv
// Wishbone-attached text console: cursor tracking, character puts and
// screen clear into an external character RAM (row*COLS+col addressing).
module wb_text_console #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  output logic [7:0]  wb_dat_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        busy
);

  localparam int unsigned XW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned YW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned AW    = 12;
  localparam int unsigned CELLS = COLS * ROWS;

  localparam logic [XW-1:0] X_MAX     = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(ROWS - 1);
  localparam logic [7:0]    X_MAX8    = 8'(COLS - 1);
  localparam logic [7:0]    Y_MAX8    = 8'(ROWS - 1);
  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);

  localparam logic [3:0] REG_CHAR   = 4'h0;
  localparam logic [3:0] REG_CUR_X  = 4'h1;
  localparam logic [3:0] REG_CUR_Y  = 4'h2;
  localparam logic [3:0] REG_CTRL   = 4'h3;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_FILL   = 4'h5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PUT,
    S_CLEAR
  } state_t;

  state_t          state;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            wrap;
  logic [7:0]      fill;
  logic [7:0]      last_char;

  logic [3:0]      reg_sel;
  logic            req;
  logic            stall;
  logic            accept;
  logic [7:0]      rd_data;
  logic [AW-1:0]   cell_addr;
  logic [XW-1:0]   put_x;
  logic [YW-1:0]   put_y;
  logic            put_wrap;
  logic            put_we;
  logic            put_lf;
  logic [XW-1:0]   wr_x;
  logic [YW-1:0]   wr_y;
  logic            unused_adr_hi;

  assign reg_sel       = wb_adr_i[3:0];
  assign unused_adr_hi = ^wb_adr_i[7:4];
  assign req           = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  // Character and control writes must wait for a running clear to finish.
  assign stall         = (state == S_CLEAR) & wb_we_i &
                         ((reg_sel == REG_CHAR) | (reg_sel == REG_CTRL));
  assign accept        = req & ~stall;
  assign cell_addr     = AW'(y) * AW'(COLS) + AW'(x);
  assign wr_x          = (wb_dat_i > X_MAX8) ? X_MAX : XW'(wb_dat_i);
  assign wr_y          = (wb_dat_i > Y_MAX8) ? Y_MAX : YW'(wb_dat_i);

  // Cursor effect of the character currently on the bus.
  always_comb begin
    put_x    = x;
    put_y    = y;
    put_wrap = wrap;
    put_we   = 1'b0;
    put_lf   = 1'b0;
    case (wb_dat_i)
      8'h0A: begin
        put_x  = '0;
        put_lf = 1'b1;
      end
      8'h0D: put_x = '0;
      8'h08: begin
        if (x != '0) put_x = x - XW'(1);
      end
      default: begin
        put_we = 1'b1;
        if (x == X_MAX) begin
          put_x  = '0;
          put_lf = 1'b1;
        end else begin
          put_x = x + XW'(1);
        end
      end
    endcase
    if (put_lf) begin
      if (y == Y_MAX) begin
        put_y    = '0;
        put_wrap = 1'b1;
      end else begin
        put_y = y + YW'(1);
      end
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (reg_sel)
      REG_CHAR:   rd_data = last_char;
      REG_CUR_X:  rd_data = 8'(x);
      REG_CUR_Y:  rd_data = 8'(y);
      REG_STATUS: rd_data = {6'd0, wrap, busy};
      REG_FILL:   rd_data = fill;
      default:    rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      x         <= '0;
      y         <= '0;
      wrap      <= 1'b0;
      fill      <= 8'h20;
      last_char <= 8'h00;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= 8'h00;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= 8'h00;
      busy      <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      ram_we   <= 1'b0;

      case (state)
        S_PUT:   state <= S_IDLE;
        S_CLEAR: begin
          // ram_addr doubles as the clear sweep pointer.
          if (ram_addr == LAST_CELL) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            x     <= '0;
            y     <= '0;
          end else begin
            ram_we   <= 1'b1;
            ram_addr <= ram_addr + AW'(1);
            ram_data <= fill;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (accept) begin
        wb_ack_o <= 1'b1;
        if (!wb_we_i) begin
          wb_dat_o <= rd_data;
        end else begin
          case (reg_sel)
            REG_CHAR: begin
              state     <= S_PUT;
              last_char <= wb_dat_i;
              x         <= put_x;
              y         <= put_y;
              wrap      <= put_wrap;
              ram_we    <= put_we;
              ram_addr  <= cell_addr;
              ram_data  <= wb_dat_i;
            end
            REG_CUR_X: x <= wr_x;
            REG_CUR_Y: y <= wr_y;
            REG_CTRL: begin
              if (wb_dat_i[2]) wrap <= 1'b0;
              if (wb_dat_i[0]) begin
                state    <= S_CLEAR;
                busy     <= 1'b1;
                ram_we   <= 1'b1;
                ram_addr <= '0;
                ram_data <= fill;
              end else if (wb_dat_i[1]) begin
                x <= '0;
                y <= '0;
              end
            end
            REG_FILL: fill <= wb_dat_i;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_text_console.sv
// Scoreboard bench for wb_text_console: a cursor/screen model predicts every
// RAM write and bus response; a negedge monitor checks them as they appear.
module tb_wb_text_console;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  wb_adr_i;
  logic [7:0]  wb_dat_i;
  logic [7:0]  wb_dat_o;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic        wb_ack_o;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data;
  logic        busy;

  wb_text_console #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_ack_o (wb_ack_o),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
    logic        busy;
  } ram_exp_t;

  typedef struct {
    bit          is_read;
    bit          is_char;
    bit          put_we;
    logic [7:0]  rdata;
  } ack_exp_t;

  ram_exp_t exp_ram[$];
  ack_exp_t exp_ack[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: cursor as plain integers.
  int         mx, my;
  bit         mwrap, mbusy;
  logic [7:0] mfill, mlast;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mx = 0; my = 0; mwrap = 0; mbusy = 0; mfill = 8'h20; mlast = 8'h00;
  endfunction

  function automatic void model_newline();
    my++;
    if (my == ROWS) begin
      my = 0;
      mwrap = 1;
    end
  endfunction

  function automatic logic [7:0] model_read(input logic [3:0] off);
    case (off)
      4'h0:    return mlast;
      4'h1:    return 8'(mx);
      4'h2:    return 8'(my);
      4'h4:    return {6'd0, mwrap, mbusy};
      4'h5:    return mfill;
      default: return 8'h00;
    endcase
  endfunction

  // Applies a register write to the model; returns 1 if a RAM cell is written by a put.
  function automatic bit model_write(input logic [3:0] off, input logic [7:0] d);
    bit we = 0;
    case (off)
      4'h0: begin
        mlast = d;
        if (d == 8'h0A) begin
          mx = 0;
          model_newline();
        end else if (d == 8'h0D) begin
          mx = 0;
        end else if (d == 8'h08) begin
          if (mx > 0) mx--;
        end else begin
          we = 1;
          exp_ram.push_back('{12'(my * COLS + mx), d, 1'b0});
          mx++;
          if (mx == COLS) begin
            mx = 0;
            model_newline();
          end
        end
      end
      4'h1: mx = (int'(d) > COLS - 1) ? COLS - 1 : int'(d);
      4'h2: my = (int'(d) > ROWS - 1) ? ROWS - 1 : int'(d);
      4'h3: begin
        if (d[2]) mwrap = 0;
        if (d[0]) begin
          for (int a = 0; a < CELLS; a++) exp_ram.push_back('{12'(a), mfill, 1'b1});
          mx = 0; my = 0; mbusy = 1;
        end else if (d[1]) begin
          mx = 0; my = 0;
        end
      end
      4'h5: mfill = d;
      default: ;
    endcase
    return we;
  endfunction

  task automatic wb_op(input bit we, input logic [3:0] off, input logic [7:0] d);
    ack_exp_t r;
    int n;
    r.is_read = !we;
    r.is_char = we && (off == 4'h0);
    r.put_we  = 0;
    r.rdata   = 8'h00;
    if (we) r.put_we = model_write(off, d);
    else    r.rdata  = model_read(off);
    exp_ack.push_back(r);
    wb_adr_i = {4'($urandom_range(0, 15)), off};
    wb_dat_i = we ? d : 8'($urandom);
    wb_we_i  = we;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!wb_ack_o && n < 4000);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    if (!wb_ack_o) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout off=%0h actual=no_ack required=ack", off);
      void'(exp_ack.pop_back());
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    check("clear_completes", 32'(busy), 32'd0);
    mbusy = 0;
  endtask

  // Monitor: every RAM strobe and every ack is matched against the scoreboard.
  bit prev_ack = 0;
  always @(negedge clk) begin
    ram_exp_t e;
    ack_exp_t a;
    if (ram_we === 1'b1) begin
      if (exp_ram.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ram_we_unexpected actual_addr=%0d actual_data=%0h required=no_write", ram_addr, ram_data);
      end else begin
        e = exp_ram.pop_front();
        check("ram_addr", 32'(ram_addr), 32'(e.addr));
        check("ram_data", 32'(ram_data), 32'(e.data));
        check("busy_at_write", 32'(busy), 32'(e.busy));
      end
    end
    if (wb_ack_o === 1'b1) begin
      check("ack_single_cycle", 32'(prev_ack), 32'd0);
      if (exp_ack.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack_unexpected actual=ack required=none");
      end else begin
        a = exp_ack.pop_front();
        if (a.is_read) check("read_data", 32'(wb_dat_o), 32'(a.rdata));
        if (a.is_char) begin
          check("put_we_with_ack", 32'(ram_we), 32'(a.put_we));
          check("char_ack_not_busy", 32'(busy), 32'd0);
        end
      end
    end
    prev_ack = wb_ack_o;
  end

  initial begin
    logic [7:0] d;
    int n;
    rst = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(wb_ack_o), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_data", 32'(ram_data), 32'd0);
    check("rst_dat_o", 32'(wb_dat_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    wb_op(0, 4'h5, 0); wb_op(0, 4'h0, 0); wb_op(0, 4'h4, 0); wb_op(0, 4'h1, 0);

    wb_op(1, 4'h0, 8'h41); wb_op(1, 4'h0, 8'h42); wb_op(0, 4'h1, 0);

    wb_op(1, 4'h1, 8'd79); wb_op(1, 4'h2, 8'd29); wb_op(1, 4'h0, 8'h5A);
    wb_op(0, 4'h1, 0); wb_op(0, 4'h2, 0); wb_op(0, 4'h4, 0);
    wb_op(1, 4'h3, 8'h04); wb_op(0, 4'h4, 0);

    wb_op(1, 4'h1, 8'd200); wb_op(0, 4'h1, 0);
    wb_op(1, 4'h2, 8'd255); wb_op(0, 4'h2, 0);
    wb_op(1, 4'h3, 8'h02); wb_op(0, 4'h1, 0); wb_op(0, 4'h2, 0); wb_op(0, 4'h3, 0);

    wb_op(1, 4'h1, 8'd5); wb_op(1, 4'h2, 8'd3);
    wb_op(1, 4'h0, 8'h0A); wb_op(0, 4'h1, 0); wb_op(0, 4'h2, 0);
    wb_op(1, 4'h0, 8'h08); wb_op(0, 4'h1, 0);
    wb_op(1, 4'h0, 8'h0D); wb_op(0, 4'h1, 0);

    wb_op(1, 4'h5, 8'h2E); wb_op(1, 4'h3, 8'h01); wb_op(0, 4'h4, 0);
    wait_idle();
    wb_op(0, 4'h1, 0); wb_op(0, 4'h2, 0);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          case ($urandom_range(0, 7))
            0:       d = 8'h0A;
            1:       d = 8'h0D;
            2:       d = 8'h08;
            default: d = 8'($urandom);
          endcase
          wb_op(1, 4'h0, d);
        end
        4: wb_op(1, 4'h1, 8'($urandom));
        5: wb_op(1, 4'h2, 8'($urandom));
        6, 7: wb_op(0, 4'($urandom_range(0, 15)), 0);
        8: begin
          d = {5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 19) == 0)};
          wb_op(1, 4'h3, d);
          if (d[0]) wait_idle();
        end
        default: begin
          if ($urandom_range(0, 1) == 0) wb_op(1, 4'h5, 8'($urandom));
          else wb_op(1, 4'($urandom_range(6, 15)), 8'($urandom));
        end
      endcase
    end

    wb_op(1, 4'h5, 8'h2D); wb_op(1, 4'h1, 8'd10);
    wb_op(1, 4'h3, 8'h03);
    wb_op(1, 4'h0, 8'h37);
    wait_idle();
    wb_op(0, 4'h1, 0); wb_op(0, 4'h2, 0);

    wb_op(1, 4'h5, 8'h55); wb_op(1, 4'h3, 8'h01);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ram_we && ram_addr == 12'd1000) && n < 4000);
    if (n >= 4000) begin
      checks++;
      errors++;
      $display("FAIL clear_reach_1000 actual=timeout required=addr_1000");
    end
    rst = 1'b1;
    @(posedge clk); #1;
    exp_ram.delete();
    exp_ack.delete();
    model_reset();
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ram_we", 32'(ram_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    wb_op(0, 4'h5, 0); wb_op(0, 4'h4, 0); wb_op(0, 4'h1, 0);

    repeat (5) @(posedge clk);
    check("ram_queue_drained", 32'(exp_ram.size()), 32'd0);
    check("ack_queue_drained", 32'(exp_ack.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
